// File: rtl/cpu_run_pkg.sv
// rtl/cpu_run_pkg.sv - run-state encoding and shared defaults for the CPU run controller
package cpu_run_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10,
    ST_STEP = 2'b11
  } run_state_e;

  localparam int DEB_CYCLES_DEF = 50000;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - button synchroniser, stability counter and one-cycle press pulse
module btn_debounce
  import cpu_run_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pulse_q;

  // The counter only runs while the synchronised input disagrees with the accepted level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_W'(DEB_CYCLES - 1)) begin
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= level_d & ~level_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - CPU run/halt/step clock-enable controller with display mux; CYCLE_CNT_EN adds a cpu_ce counter
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int DIV_W      = 25,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 16
) (
  input  logic                       clk_in,
  input  logic                       reset_n,
  input  logic                       btn_run,
  input  logic                       btn_halt,
  input  logic                       btn_step,
  input  logic                       btn_ch,
  input  logic                       halt_req,
  input  logic [4:0]                 div_sel,
  input  logic [NUM_CH*CH_W-1:0]     ch_data,
  output logic                       cpu_ce,
  output logic [1:0]                 run_state,
  output logic [$clog2(NUM_CH)-1:0]  ch_sel,
  output logic [31:0]                disp_data
);

  localparam int SEL_W = $clog2(NUM_CH);

  logic [1:0]       rst_sync_q;
  logic             rst_n_int;
  logic             run_p, halt_p, step_p, ch_p;
  run_state_e       state_q, state_d;
  logic [DIV_W-1:0] presc_q, presc_d, presc_max;
  logic [4:0]       div_eff, div_q;
  logic             ce_d, cpu_ce_q;
  logic [SEL_W-1:0] ch_sel_q, ch_sel_d;
  logic [15:0]      disp_lo_q;
  logic [CH_W+15:0] ch_ext;

  // Assertion reaches every flop at once; release is aligned to clk_in.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run  (.clk_i(clk_in), .rst_n_i(rst_n_int), .btn_i(btn_run),  .pulse_o(run_p));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_halt (.clk_i(clk_in), .rst_n_i(rst_n_int), .btn_i(btn_halt), .pulse_o(halt_p));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (.clk_i(clk_in), .rst_n_i(rst_n_int), .btn_i(btn_step), .pulse_o(step_p));
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ch   (.clk_i(clk_in), .rst_n_i(rst_n_int), .btn_i(btn_ch),   .pulse_o(ch_p));

  assign div_eff   = (div_sel > 5'(DIV_W - 1)) ? 5'(DIV_W - 1) : div_sel;
  assign presc_max = ~({DIV_W{1'b1}} << div_eff);

  // A pending halt outranks run/step even in states where it causes no transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (!(halt_req || halt_p)) begin
          if (run_p)       state_d = ST_RUN;
          else if (step_p) state_d = ST_STEP;
        end
      end
      ST_RUN:  if (halt_req || halt_p) state_d = ST_HALT;
      ST_STEP: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  // cpu_ce is decided from the next state so it can never appear in IDLE or HALT.
  always_comb begin
    presc_d = '0;
    if (state_q == ST_RUN && state_d == ST_RUN && div_eff == div_q) begin
      presc_d = (presc_q >= presc_max) ? '0 : presc_q + 1'b1;
    end
    ce_d = (state_d == ST_STEP) || (state_d == ST_RUN && presc_d == presc_max);
  end

  always_comb begin
    ch_sel_d = ch_sel_q;
    if (ch_p) ch_sel_d = (ch_sel_q == SEL_W'(NUM_CH - 1)) ? '0 : ch_sel_q + 1'b1;
    ch_ext = {16'h0000, ch_data[ch_sel_q*CH_W +: CH_W]};
  end

  always_ff @(posedge clk_in or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      div_q     <= '0;
      cpu_ce_q  <= 1'b0;
      ch_sel_q  <= '0;
      disp_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      div_q     <= div_eff;
      cpu_ce_q  <= ce_d;
      ch_sel_q  <= ch_sel_d;
      disp_lo_q <= ch_ext[15:0];
    end
  end

`ifdef CYCLE_CNT_EN
  logic [31:0] cyc_q;

  always_ff @(posedge clk_in or negedge rst_n_int) begin
    if (!rst_n_int)    cyc_q <= '0;
    else if (cpu_ce_q) cyc_q <= cyc_q + 32'd1;
  end

  assign disp_data = {cyc_q[15:0], disp_lo_q};
`else
  assign disp_data = {14'b0, state_q, disp_lo_q};
`endif

  assign cpu_ce    = cpu_ce_q;
  assign run_state = state_q;
  assign ch_sel    = ch_sel_q;

endmodule
